conv3_1_window_mac: RTL

- Convolution compute stage directly downstream of the conv3_1 weight ROM.
- Fetches the 36-weight packed bus once: 4 output kernels x 9 taps, signed Q8.8.
- Then accepts 3x3 input windows over a valid/ready handshake. For each window, computes 4 output-channel dot products sequentially, one tap per cycle with 4 parallel MACs.
- Emits a packed 4x16-bit result to the next layer stage.

---
 rtl/conv3_1_pkg.sv | 38 +++
 rtl/conv3_1_mac_lane.sv | 52 +++++
 rtl/conv3_1_window_mac.sv | 110 +++++++++++
 3 files changed

// File: rtl/conv3_1_pkg.sv
// conv3_1_pkg -- shared constants, FSM state type and the Q8.8 scale/saturate
// helper for the conv3_1 window MAC stage.
//   DATA_W    : sample/weight width (signed)
//   FRAC_BITS : fractional bits of the Q format
//   TAPS      : taps per 3x3 kernel
//   N_CH      : output channels computed in parallel
//   ACC_W     : accumulator width (full product plus 4 guard bits)
package conv3_1_pkg;

  localparam int DATA_W    = 16;
  localparam int FRAC_BITS = 8;
  localparam int TAPS      = 9;
  localparam int N_CH      = 4;
  localparam int ACC_W     = 2*DATA_W + 4;
  localparam int WIDX_W    = $clog2(N_CH*TAPS);

  typedef enum logic [2:0] {
    ST_WREQ  = 3'd0,
    ST_WWAIT = 3'd1,
    ST_IDLE  = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2**(DATA_W-1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2**(DATA_W-1)));

  // Drop the fractional bits (arithmetic shift floors toward -inf), then
  // clamp into the signed DATA_W range.
  function automatic logic [DATA_W-1:0] scale_sat(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] sh;
    sh = acc >>> FRAC_BITS;
    if (sh > SAT_MAX)      return SAT_MAX[DATA_W-1:0];
    else if (sh < SAT_MIN) return SAT_MIN[DATA_W-1:0];
    else                   return sh[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/conv3_1_mac_lane.sv
// conv3_1_mac_lane -- one output channel: signed MAC with clear/enable and a
// registered, scaled and saturated result.
//   clk, rst : clock, async active-high reset
//   clr      : zero the accumulator (window accept)
//   en       : accumulate pix*w this cycle
//   last     : this is the final tap; register the scaled result
//   pix, w   : current tap sample and weight (signed Q8.8)
//   res      : result word, held until the next window's last tap
// Build option: CONV3_1_RELU_EN clamps negative results to zero.
module conv3_1_mac_lane
  import conv3_1_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic              last,
  input  logic [DATA_W-1:0] pix,
  input  logic [DATA_W-1:0] w,
  output logic [DATA_W-1:0] res
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    sum;
  logic        [DATA_W-1:0]   res_d;

  assign prod = $signed(pix) * $signed(w);
  // Final sum includes the current product so the result lands on the
  // same edge as the last accumulate.
  assign sum  = acc + ACC_W'(prod);

  always_comb begin
    res_d = scale_sat(sum);
`ifdef CONV3_1_RELU_EN
    if (res_d[DATA_W-1]) res_d = '0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      res <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
      if (last) res <= res_d;
    end
  end

endmodule

// File: rtl/conv3_1_window_mac.sv
// conv3_1_window_mac -- conv3_1 compute stage. Fetches the 36-word weight
// bus once after reset, then takes 3x3 windows over valid/ready and produces
// four channel dot products, one tap per cycle across four parallel MACs.
//   clk, rst  : clock, async active-high reset
//   w_start   : one-cycle fetch request to the weight ROM
//   w_data    : packed weights, word c*TAPS+k at [16*(c*TAPS+k) +: 16]
//   win_valid/win_ready/win_data : window input, tap k at [16*k +: 16]
//   out_valid/out_ready/out_data : result, channel c at [16*c +: 16]
//   busy      : high whenever the stage is not idle
// Build option: CONV3_1_RELU_EN (zero negative channel results).
module conv3_1_window_mac
  import conv3_1_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  output logic                          w_start,
  input  logic [N_CH*TAPS*DATA_W-1:0]   w_data,
  input  logic                          win_valid,
  output logic                          win_ready,
  input  logic [TAPS*DATA_W-1:0]        win_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N_CH*DATA_W-1:0]        out_data,
  output logic                          busy
);

  localparam logic [3:0] LAST_TAP = 4'(TAPS-1);

  state_e                              state;
  logic [3:0]                          tap;
  logic [TAPS-1:0][DATA_W-1:0]         pix_q;
  logic [N_CH*TAPS-1:0][DATA_W-1:0]    w_q;
  logic [N_CH-1:0][DATA_W-1:0]         res;
  logic                                accept;
  logic                                run;
  logic                                last;

  assign win_ready = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign accept    = win_ready & win_valid;
  assign run       = (state == ST_RUN);
  assign last      = run & (tap == LAST_TAP);
  assign out_data  = res;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_WREQ;
      w_start <= 1'b0;
      busy    <= 1'b0;
      tap     <= '0;
      pix_q   <= '0;
      w_q     <= '0;
    end else begin
      case (state)
        ST_WREQ: begin
          w_start <= 1'b1;
          busy    <= 1'b1;
          state   <= ST_WWAIT;
        end
        // The ROM answers one cycle after it sees w_start, so the first
        // WWAIT cycle only drops the request; the second latches the bus.
        ST_WWAIT: begin
          if (w_start) begin
            w_start <= 1'b0;
          end else begin
            w_q   <= w_data;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (win_valid) begin
            pix_q <= win_data;
            tap   <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          tap <= tap + 4'd1;
          if (tap == LAST_TAP) state <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_WREQ;
      endcase
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_lane
    logic [WIDX_W-1:0] widx;
    assign widx = WIDX_W'(c*TAPS) + WIDX_W'(tap);

    conv3_1_mac_lane u_lane (
      .clk  (clk),
      .rst  (rst),
      .clr  (accept),
      .en   (run),
      .last (last),
      .pix  (pix_q[tap]),
      .w    (w_q[widx]),
      .res  (res[c])
    );
  end

endmodule
